// File: rtl/demux_pkg.sv
// Shared constants and elaboration helpers for the N-channel stream demultiplexer.
package demux_pkg;

    localparam int unsigned ERR_CNT_W = 8;

    // Width helper that never returns 0, so a 2-entry range still gets a 1-bit field.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    function automatic logic is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/demux_chan_fifo.sv
// Per-channel synchronous FIFO: push/pop, full/empty flags and head-word output.
module demux_chan_fifo #(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    generate
        if (DEPTH == 1) begin : g_one
            logic         vld;
            logic [W-1:0] data;

            // Push only when empty and pop only when full, so the two never coincide.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld  <= 1'b0;
                    data <= '0;
                end else if (push && !vld) begin
                    vld  <= 1'b1;
                    data <= push_data;
                end else if (pop && vld) begin
                    vld <= 1'b0;
                end
            end

            assign full  = vld;
            assign empty = !vld;
            assign head  = data;
        end else begin : g_multi
            localparam int unsigned AW = $clog2(DEPTH);

            logic [AW:0]  wr_ptr;
            logic [AW:0]  rd_ptr;
            logic [W-1:0] mem [DEPTH];
            logic [W-1:0] last_q;
            logic         do_push;
            logic         do_pop;

            assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
            assign empty   = (wr_ptr == rd_ptr);
            assign do_push = push && !full;
            assign do_pop  = pop && !empty;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    last_q <= '0;
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        mem[i] <= '0;
                    end
                end else begin
                    if (do_push) begin
                        mem[wr_ptr[AW-1:0]] <= push_data;
                        wr_ptr              <= wr_ptr + 1'b1;
                    end
                    if (do_pop) begin
                        last_q <= mem[rd_ptr[AW-1:0]];
                        rd_ptr <= rd_ptr + 1'b1;
                    end
                end
            end

            // The slot behind the read pointer is stale once the FIFO drains; the last
            // popped word is kept separately so an idle channel keeps showing it.
            assign head = empty ? last_q : mem[rd_ptr[AW-1:0]];
        end
    endgenerate

endmodule

// File: rtl/demux_stream_nch.sv
// Registered 1-to-N valid/ready stream demultiplexer with a FIFO per output channel.
// Build option DEMUX_STREAM_NCH_ZERO_IDLE_EN: zero out_data on channels with out_valid low.
module demux_stream_nch
    import demux_pkg::*;
#(
    parameter int unsigned W     = 16,
    parameter int unsigned N     = 4,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned SEL_W = clog2_min1(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [W-1:0]         in_data,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [N*W-1:0]       out_data,
    output logic [N-1:0]         out_valid,
    input  logic [N-1:0]         out_ready,
    output logic                 sel_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    generate
        if (N < 2 || N > 16) begin : g_bad_n
            $error("demux_stream_nch: N must be in 2..16");
        end
        if (!is_pow2(DEPTH) || DEPTH > 16) begin : g_bad_depth
            $error("demux_stream_nch: DEPTH must be a power of two in 1..16");
        end
        if (W < 1) begin : g_bad_w
            $error("demux_stream_nch: W must be at least 1");
        end
    endgenerate

    logic [N-1:0] sel_hit;
    logic [N-1:0] full;
    logic [N-1:0] empty;
    logic [N-1:0] push;
    logic         sel_full;
    logic         sel_in_range;
    logic         accept;
    logic         oor_drop;

    // Decoding against each channel index keeps out-of-range selects (non power-of-two N)
    // from ever indexing past the channel vectors.
    always_comb begin
        sel_hit  = '0;
        sel_full = 1'b0;
        for (int unsigned c = 0; c < N; c++) begin
            if (in_sel == SEL_W'(c)) begin
                sel_hit[c] = 1'b1;
                sel_full   = full[c];
            end
        end
    end

    assign sel_in_range = |sel_hit;
    assign in_ready     = !rst && !(sel_in_range && sel_full);
    assign accept       = in_valid && in_ready;
    assign push         = sel_hit & {N{accept}};
    assign oor_drop     = accept && !sel_in_range;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_err <= 1'b0;
            err_cnt <= '0;
        end else begin
            sel_err <= oor_drop;
            if (oor_drop && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

    generate
        for (genvar c = 0; c < N; c++) begin : g_ch
            logic [W-1:0] head;

            demux_chan_fifo #(
                .W     (W),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk       (clk),
                .rst       (rst),
                .push      (push[c]),
                .push_data (in_data),
                .pop       (out_ready[c]),
                .full      (full[c]),
                .empty     (empty[c]),
                .head      (head)
            );

            assign out_valid[c] = !empty[c];
`ifdef DEMUX_STREAM_NCH_ZERO_IDLE_EN
            assign out_data[c*W +: W] = empty[c] ? '0 : head;
`else
            assign out_data[c*W +: W] = head;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_demux_stream_nch.sv
// Randomized bench for demux_stream_nch: a 4-channel/DEPTH-2 and a 3-channel/DEPTH-1 instance
// share stimulus and are each compared against a per-channel queue model.
module tb_demux_stream_nch;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic [3:0]  out_ready;

    logic        ir_a, se_a;
    logic [63:0] od_a;
    logic [3:0]  ov_a;
    logic [7:0]  ec_a;
    logic        ir_b, se_b;
    logic [47:0] od_b;
    logic [2:0]  ov_b;
    logic [7:0]  ec_b;

    always #5 clk = ~clk;

    demux_stream_nch #(.W(16), .N(4), .DEPTH(2)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
        .in_ready(ir_a), .out_data(od_a), .out_valid(ov_a), .out_ready(out_ready),
        .sel_err(se_a), .err_cnt(ec_a)
    );

    demux_stream_nch #(.W(16), .N(3), .DEPTH(1)) u_dut3 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
        .in_ready(ir_b), .out_data(od_b), .out_valid(ov_b), .out_ready(out_ready[2:0]),
        .sel_err(se_b), .err_cnt(ec_b)
    );

    // Reference model: one queue per channel per instance.
    int unsigned nch [2] = '{4, 3};
    int unsigned dep [2] = '{2, 1};
    logic [15:0] q    [2][4][$];
    logic [15:0] last [2][4];
    logic [7:0]  m_err  [2];
    logic        m_serr [2];
    logic        stalled;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic ir_of(input int d);
        return (d == 0) ? ir_a : ir_b;
    endfunction
    function automatic logic [3:0] ov_of(input int d);
        return (d == 0) ? ov_a : {1'b0, ov_b};
    endfunction
    function automatic logic [15:0] od_of(input int d, input int c);
        return (d == 0) ? od_a[c*16 +: 16] : od_b[c*16 +: 16];
    endfunction
    function automatic logic se_of(input int d);
        return (d == 0) ? se_a : se_b;
    endfunction
    function automatic logic [7:0] ec_of(input int d);
        return (d == 0) ? ec_a : ec_b;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 4; c++) begin
                q[d][c].delete();
                last[d][c] = '0;
            end
            m_err[d]  = '0;
            m_serr[d] = 1'b0;
        end
    endtask

    // One clock: compare outputs at the falling edge, advance the model at the rising edge.
    task automatic cyc();
        logic acc  [2];
        logic rexp [2];
        logic [15:0] exp_d;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            rexp[d] = !rst && ((int'(in_sel) >= int'(nch[d])) || (q[d][in_sel].size() < int'(dep[d])));
            check($sformatf("d%0d in_ready", d), ir_of(d), rexp[d]);
            for (int c = 0; c < int'(nch[d]); c++) begin
                check($sformatf("d%0d ch%0d valid", d, c), ov_of(d)[c], q[d][c].size() != 0);
                if (q[d][c].size() != 0) exp_d = q[d][c][0];
`ifdef DEMUX_STREAM_NCH_ZERO_IDLE_EN
                else exp_d = '0;
`else
                else exp_d = last[d][c];
`endif
                check($sformatf("d%0d ch%0d data", d, c), od_of(d, c), exp_d);
            end
            check($sformatf("d%0d sel_err", d), se_of(d), m_serr[d]);
            check($sformatf("d%0d err_cnt", d), ec_of(d), m_err[d]);
            acc[d] = in_valid && rexp[d];
        end
        stalled = in_valid && !rexp[0] && !rst;
        @(posedge clk);
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < int'(nch[d]); c++) begin
                    if (out_ready[c] && q[d][c].size() != 0) last[d][c] = q[d][c].pop_front();
                end
                m_serr[d] = acc[d] && (int'(in_sel) >= int'(nch[d]));
                if (acc[d]) begin
                    if (int'(in_sel) < int'(nch[d])) q[d][in_sel].push_back(in_data);
                    else if (m_err[d] != 8'hFF) m_err[d] = m_err[d] + 8'd1;
                end
            end
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [15:0] dt);
        in_valid = v;
        in_sel   = s;
        in_data  = dt;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        check("reset immediate", {ov_a, ov_b, ec_a, ec_b, se_a, se_b, ir_a, ir_b}, '0);
        model_reset();
        cyc();
        rst = 1'b0;
    endtask

    // Producer hold rule on the primary instance: no change while stalled.
    logic        stall_q = 1'b0;
    logic [17:0] held_q;
    always @(posedge clk) begin
        if (stall_q && !rst)
            assert ({in_sel, in_data} == held_q) else $error("input changed while stalled");
        stall_q <= in_valid && !ir_a && !rst;
        held_q  <= {in_sel, in_data};
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 2'd0, 16'h0);
        out_ready = '0;
        stalled = 1'b0;
        model_reset();
        #1;
        check("reset state", {ov_a, ov_b, ec_a, ec_b, se_a, se_b, ir_a, ir_b}, '0);
        check("reset data", {od_a, od_b}, '0);
        cyc();
        cyc();
        rst = 1'b0;

        // Reset during traffic: buffered word never delivered.
        drive(1'b1, 2'd1, 16'h1111);
        cyc();
        in_valid = 1'b0;
        pulse_reset();
        out_ready = 4'hF;
        repeat (3) cyc();
        check("reset discards", ov_a, 4'b0000);

        // Basic routing.
        drive(1'b1, 2'd0, 16'hAAAA);
        cyc();
        check("route ch0", {ov_a, od_a[15:0]}, {4'b0001, 16'hAAAA});
        drive(1'b1, 2'd3, 16'hBBBB);
        cyc();
        in_valid = 1'b0;
        check("route ch3", {ov_a, od_a[63:48]}, {4'b1000, 16'hBBBB});
        cyc();
        check("route one cycle", ov_a, 4'b0000);

        // Backpressure isolation on ch2.
        out_ready = 4'b1011;
        drive(1'b1, 2'd2, 16'h0001); cyc();
        drive(1'b1, 2'd2, 16'h0002); cyc();
        drive(1'b1, 2'd2, 16'h0003);
        repeat (3) cyc();
        check("bp stall", ir_a, 1'b0);
        out_ready = 4'hF;
        cyc();
        check("bp no bypass", ir_a, 1'b1);
        cyc();
        drive(1'b1, 2'd0, 16'h0004);
        cyc();
        in_valid = 1'b0;
        check("bp ch0 delivers", {ov_a[0], od_a[15:0]}, {1'b1, 16'h0004});
        repeat (4) cyc();

        // Full FIFO with simultaneous pop: no push that cycle.
        out_ready = 4'b1101;
        drive(1'b1, 2'd1, 16'h0101); cyc();
        drive(1'b1, 2'd1, 16'h0102); cyc();
        out_ready = 4'hF;
        drive(1'b1, 2'd1, 16'h0103);
        check("full ready low", ir_a, 1'b0);
        cyc();
        check("full ready after pop", ir_a, 1'b1);
        cyc();
        in_valid = 1'b0;
        repeat (4) cyc();

        // Idle data after a pop.
        out_ready = 4'h0;
        drive(1'b1, 2'd0, 16'hCAFE);
        cyc();
        in_valid = 1'b0;
        out_ready = 4'h1;
        cyc();
`ifdef DEMUX_STREAM_NCH_ZERO_IDLE_EN
        check("idle data", {ov_a[0], od_a[15:0]}, {1'b0, 16'h0000});
`else
        check("idle data", {ov_a[0], od_a[15:0]}, {1'b0, 16'hCAFE});
`endif

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if (!stalled) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_sel   = 2'($urandom_range(0, 3));
                in_data  = 16'($urandom);
            end
            out_ready = 4'($urandom);
            if ($urandom_range(0, 199) == 0) pulse_reset();
            else cyc();
        end

        // Out-of-range flood on the 3-channel instance: err_cnt saturates.
        out_ready = 4'hF;
        in_valid  = 1'b1;
        in_sel    = 2'd3;
        for (int i = 0; i < 300; i++) begin
            in_data = 16'($urandom);
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        check("err_cnt saturates", ec_b, 8'd255);
        check("sel_err ends", se_b, 1'b0);
        check("oor no valid", ov_b, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
